histeq_remap: RTL and testbench

Parametrised, double-buffered histogram-equalisation remapper. Accepts a per-level CDF stream from the histogram accumulator and builds a normalised LUT in a back bank with a sequential divider: round((cdf − cdf_min)·(2^DATA_W−1) / (IMG_TOTAL − cdf_min)). At the next frame start it swaps banks and remaps the live pixel stream through the front bank with fixed latency. It sits between the histogram statistics block and the downstream video pipeline, replacing the per-pixel divider with a per-level build.

---
 rtl/histeq_pkg.sv | 23 ++
 rtl/histeq_div.sv | 60 ++++++
 rtl/histeq_remap.sv | 173 +++++++++++++++++
 tb/tb_histeq_remap.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/histeq_pkg.sv
// Shared types and width helpers for the histogram-equalisation remapper.
package histeq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    WRITE,
    PEND
  } state_t;

  function automatic int num_width(input int data_w, input int cnt_w);
    return data_w + cnt_w;
  endfunction

  function automatic int lut_depth(input int data_w);
    return 1 << data_w;
  endfunction

  function automatic int max_val(input int data_w);
    return (1 << data_w) - 1;
  endfunction

endpackage

// File: rtl/histeq_div.sv
// Sequential restoring divider, one quotient bit per cycle, NUM_W cycles per divide.
// done is high during the final iteration; quotient is valid the following cycle.
module histeq_div #(
  parameter int NUM_W = 28,
  parameter int DEN_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  localparam int CNT_BITS = $clog2(NUM_W + 1);

  logic [NUM_W-1:0]    num_q;
  logic [DEN_W-1:0]    den_q;
  logic [DEN_W-1:0]    rem_q;
  logic [DEN_W:0]      rem_shift;
  logic [DEN_W:0]      rem_sub;
  logic [CNT_BITS-1:0] cnt_q;

  // The partial remainder always stays below den, so it fits in DEN_W bits.
  assign rem_shift = {rem_q, num_q[NUM_W-1]};
  assign rem_sub   = rem_shift - {1'b0, den_q};
  assign done      = busy && (cnt_q == CNT_BITS'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q    <= '0;
      den_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      quotient <= '0;
    end else if (start) begin
      num_q    <= num;
      den_q    <= den;
      rem_q    <= '0;
      cnt_q    <= CNT_BITS'(NUM_W);
      busy     <= 1'b1;
      quotient <= '0;
    end else if (busy) begin
      num_q <= num_q << 1;
      if (!rem_sub[DEN_W]) begin
        rem_q    <= rem_sub[DEN_W-1:0];
        quotient <= {quotient[NUM_W-2:0], 1'b1};
      end else begin
        rem_q    <= rem_shift[DEN_W-1:0];
        quotient <= {quotient[NUM_W-2:0], 1'b0};
      end
      cnt_q <= cnt_q - CNT_BITS'(1);
      if (cnt_q == CNT_BITS'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/histeq_remap.sv
// Double-buffered histogram-equalisation LUT: builds a normalised table from the CDF
// stream into the back bank, swaps on vsync, and remaps pixels with 2-cycle latency.
module histeq_remap
  import histeq_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 20,
  parameter int IMG_TOTAL = 480000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] cdf_level,
  input  logic [CNT_W-1:0]  cdf_count,
  input  logic              cdf_valid,
  output logic              cdf_ready,
  input  logic              bypass_en,
  input  logic              per_vsync,
  input  logic              per_href,
  input  logic [DATA_W-1:0] per_gray,
  output logic              post_vsync,
  output logic              post_href,
  output logic [DATA_W-1:0] post_gray,
  output logic              table_valid,
  output logic              swap_pulse,
  output logic              cdf_err
);

  localparam int NUM_W     = num_width(DATA_W, CNT_W);
  localparam int LUT_DEPTH = lut_depth(DATA_W);
  localparam int MAXV      = max_val(DATA_W);
  localparam logic [DATA_W-1:0] LAST_LEVEL = DATA_W'(MAXV);

  state_t state_q, state_d;

  logic [DATA_W-1:0] level_q, entry_q, wr_entry, rd_q;
  logic [CNT_W-1:0]  cdf_min_q, min_eff, den_eff, diff;
  logic [NUM_W-1:0]  num, quotient;
  logic              use_div_q, ident_back_q, ident_front_q, bank_sel_q, vsync_d_q;
  logic              min_zero, den_zero, vsync_rise;
  logic              div_start, div_busy, div_done, do_accept, do_err, do_swap;
  logic              vsync1_q, href1_q, pass1_q;
  logic [DATA_W-1:0] gray1_q;
  logic [DATA_W-1:0] lut [2*LUT_DEPTH];

  assign min_eff    = (cdf_min_q != '0) ? cdf_min_q : cdf_count;
  assign min_zero   = (min_eff == '0);
  assign den_eff    = CNT_W'(IMG_TOTAL) - min_eff;
  assign den_zero   = (den_eff == '0);
  assign diff       = cdf_count - min_eff;
  assign num        = NUM_W'(diff) * NUM_W'(MAXV) + NUM_W'(den_eff >> 1);
  assign vsync_rise = per_vsync && !vsync_d_q;
  assign wr_entry   = !use_div_q ? entry_q :
                      (quotient > NUM_W'(MAXV)) ? LAST_LEVEL : quotient[DATA_W-1:0];

  histeq_div #(.NUM_W(NUM_W), .DEN_W(CNT_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .num      (num),
    .den      (den_eff),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cdf_ready = 1'b0;
    div_start = 1'b0;
    do_accept = 1'b0;
    do_err    = 1'b0;
    do_swap   = 1'b0;
    case (state_q)
      IDLE: begin
        cdf_ready = 1'b1;
        if (cdf_valid) begin
          if (cdf_level != level_q) begin
            do_err = 1'b1;
          end else begin
            do_accept = 1'b1;
            if (min_zero || den_zero) begin
              state_d = WRITE;
            end else begin
              div_start = 1'b1;
              state_d   = DIV;
            end
          end
        end
      end
      DIV:     if (div_done || !div_busy) state_d = WRITE;
      WRITE:   state_d = (level_q == LAST_LEVEL) ? PEND : IDLE;
      PEND: begin
        if (vsync_rise) begin
          do_swap = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A single-level image (den==0) is flagged so the whole table behaves as identity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q       <= '0;
      cdf_min_q     <= '0;
      entry_q       <= '0;
      use_div_q     <= 1'b0;
      ident_back_q  <= 1'b0;
      ident_front_q <= 1'b0;
      bank_sel_q    <= 1'b0;
      table_valid   <= 1'b0;
      swap_pulse    <= 1'b0;
      cdf_err       <= 1'b0;
      vsync_d_q     <= 1'b0;
    end else begin
      swap_pulse <= do_swap;
      cdf_err    <= do_err;
      vsync_d_q  <= per_vsync;
      if (do_err) begin
        level_q      <= '0;
        cdf_min_q    <= '0;
        ident_back_q <= 1'b0;
      end
      if (do_accept) begin
        cdf_min_q <= min_eff;
        use_div_q <= !(min_zero || den_zero);
        entry_q   <= min_zero ? '0 : cdf_level;
        if (!min_zero && den_zero) ident_back_q <= 1'b1;
      end
      if (state_q == WRITE && level_q != LAST_LEVEL) level_q <= level_q + DATA_W'(1);
      if (do_swap) begin
        bank_sel_q    <= ~bank_sel_q;
        table_valid   <= 1'b1;
        level_q       <= '0;
        cdf_min_q     <= '0;
        ident_front_q <= ident_back_q;
        ident_back_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == WRITE) lut[{~bank_sel_q, level_q}] <= wr_entry;
    rd_q <= lut[{bank_sel_q, per_gray}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync1_q   <= 1'b0;
      href1_q    <= 1'b0;
      gray1_q    <= '0;
      pass1_q    <= 1'b0;
      post_vsync <= 1'b0;
      post_href  <= 1'b0;
      post_gray  <= '0;
    end else begin
      vsync1_q   <= per_vsync;
      href1_q    <= per_href;
      gray1_q    <= per_gray;
      pass1_q    <= bypass_en || !table_valid || ident_front_q;
      post_vsync <= vsync1_q;
      post_href  <= href1_q;
      post_gray  <= pass1_q ? gray1_q : rd_q;
    end
  end

endmodule

// File: tb/tb_histeq_remap.sv
// Scoreboard bench for histeq_remap: pixel expectations are queued at issue time and
// popped by a monitor whenever post_href is high; sync delay and status are also checked.
module tb_histeq_remap;

  localparam int DATA_W    = 8;
  localparam int CNT_W     = 11;
  localparam int IMG_TOTAL = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] cdf_level = '0;
  logic [CNT_W-1:0]  cdf_count = '0;
  logic              cdf_valid = 1'b0;
  logic              cdf_ready;
  logic              bypass_en = 1'b0;
  logic              per_vsync = 1'b0;
  logic              per_href = 1'b0;
  logic [DATA_W-1:0] per_gray = '0;
  logic              post_vsync, post_href, table_valid, swap_pulse, cdf_err;
  logic [DATA_W-1:0] post_gray;

  typedef struct {
    int gray;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  int   swap_cnt = 0;
  int   err_cnt = 0;
  logic vs_m1, vs_m2, hr_m1, hr_m2;

  histeq_remap #(.DATA_W(DATA_W), .CNT_W(CNT_W), .IMG_TOTAL(IMG_TOTAL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cdf_level   (cdf_level),
    .cdf_count   (cdf_count),
    .cdf_valid   (cdf_valid),
    .cdf_ready   (cdf_ready),
    .bypass_en   (bypass_en),
    .per_vsync   (per_vsync),
    .per_href    (per_href),
    .per_gray    (per_gray),
    .post_vsync  (post_vsync),
    .post_href   (post_href),
    .post_gray   (post_gray),
    .table_valid (table_valid),
    .swap_pulse  (swap_pulse),
    .cdf_err     (cdf_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference two-cycle sync delay.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_m1 <= 1'b0; vs_m2 <= 1'b0; hr_m1 <= 1'b0; hr_m2 <= 1'b0;
    end else begin
      vs_m1 <= per_vsync; vs_m2 <= vs_m1; hr_m1 <= per_href; hr_m2 <= hr_m1;
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin : monitor
      exp_t e;
      check_output("post_vsync", int'(post_vsync), int'(vs_m2));
      check_output("post_href", int'(post_href), int'(hr_m2));
      if (post_href) begin
        if (sb.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_pixel: got %0d, expected none", post_gray);
        end else begin
          e = sb.pop_front();
          check_output("pixel_gray", int'(post_gray), e.gray);
          check_output("pixel_latency", cyc, e.cyc);
        end
      end
      if (swap_pulse) swap_cnt++;
      if (cdf_err) err_cnt++;
    end
  end

  task automatic apply_stimulus(input int g, input int exp_g);
    exp_t e;
    per_gray = DATA_W'(g);
    per_href = 1'b1;
    e.gray = exp_g;
    e.cyc  = cyc + 2;
    sb.push_back(e);
    @(posedge clk); #1;
    per_href = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic feed_word(input int level, input int count);
    int   waited;
    logic rdy;
    waited    = 0;
    cdf_level = DATA_W'(level);
    cdf_count = CNT_W'(count);
    cdf_valid = 1'b1;
    forever begin
      @(negedge clk);
      rdy = cdf_ready;
      @(posedge clk); #1;
      if (rdy) break;
      waited++;
      if (waited > 200) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL cdf_accept_timeout: got no ready, expected accept of level %0d", level);
        break;
      end
    end
    cdf_valid = 1'b0;
  endtask

  function automatic int cdf_of(input int mode, input int l);
    case (mode)
      1:       return 4 * (l + 1);
      2:       return (l < 255) ? 512 : 1024;
      default: return (l < 100) ? 0 : 1024;
    endcase
  endfunction

  task automatic feed_table(input int mode);
    for (int l = 0; l < 256; l++) feed_word(l, cdf_of(mode, l));
    idle(40);
  endtask

  task automatic vsync_pulse();
    per_vsync = 1'b1;
    idle(3);
    per_vsync = 1'b0;
    idle(3);
  endtask

  initial begin
    idle(3);
    check_output("reset_post_gray", int'(post_gray), 0);
    check_output("reset_post_vsync", int'(post_vsync), 0);
    check_output("reset_post_href", int'(post_href), 0);
    check_output("reset_table_valid", int'(table_valid), 0);
    check_output("reset_swap_pulse", int'(swap_pulse), 0);
    check_output("reset_cdf_err", int'(cdf_err), 0);
    rst_n = 1'b1;
    idle(1);
    check_output("ready_after_reset", int'(cdf_ready), 1);

    // No table yet: pixels pass through.
    apply_stimulus(10, 10);
    apply_stimulus(200, 200);
    apply_stimulus(255, 255);
    idle(4);

    // Linear CDF gives an identity table.
    feed_table(1);
    check_output("pend_ready_low", int'(cdf_ready), 0);
    check_output("pend_table_invalid", int'(table_valid), 0);
    check_output("pend_no_swap", swap_cnt, 0);
    apply_stimulus(77, 77);
    idle(4);
    vsync_pulse();
    check_output("swap1_count", swap_cnt, 1);
    check_output("swap1_table_valid", int'(table_valid), 1);
    check_output("swap1_ready", int'(cdf_ready), 1);
    for (int k = 0; k < 256; k++) apply_stimulus(k, k);
    idle(4);

    // Half/half table built while the identity table stays live mid-frame.
    fork
      feed_table(2);
      begin
        for (int i = 0; i < 64; i++) begin
          apply_stimulus(128, 128);
          idle(20);
        end
      end
    join
    check_output("midframe_ready_low", int'(cdf_ready), 0);
    check_output("midframe_no_swap", swap_cnt, 1);
    apply_stimulus(128, 128);
    apply_stimulus(0, 0);
    apply_stimulus(255, 255);
    idle(4);
    vsync_pulse();
    check_output("swap2_count", swap_cnt, 2);
    apply_stimulus(0, 0);
    apply_stimulus(128, 0);
    apply_stimulus(255, 255);
    apply_stimulus(200, 0);
    apply_stimulus(254, 0);
    bypass_en = 1'b1;
    apply_stimulus(128, 128);
    apply_stimulus(200, 200);
    bypass_en = 1'b0;
    apply_stimulus(128, 0);
    idle(4);

    // Out-of-order level discards the partial table.
    feed_word(0, 0);
    feed_word(1, 0);
    feed_word(3, 0);
    idle(3);
    check_output("err_count", err_cnt, 1);
    check_output("err_ready", int'(cdf_ready), 1);
    feed_table(3);
    check_output("err_no_extra", err_cnt, 1);
    apply_stimulus(37, 0);
    idle(4);
    vsync_pulse();
    check_output("swap3_count", swap_cnt, 3);
    apply_stimulus(37, 37);
    apply_stimulus(100, 100);
    apply_stimulus(0, 0);
    apply_stimulus(255, 255);
    idle(4);

    // Reset in the middle of a divide.
    feed_word(0, 4);
    feed_word(1, 8);
    idle(5);
    check_output("div_ready_low", int'(cdf_ready), 0);
    rst_n = 1'b0;
    idle(2);
    check_output("midreset_table_valid", int'(table_valid), 0);
    check_output("midreset_post_gray", int'(post_gray), 0);
    check_output("midreset_swap_pulse", int'(swap_pulse), 0);
    rst_n = 1'b1;
    idle(1);
    check_output("midreset_ready", int'(cdf_ready), 1);
    apply_stimulus(128, 128);
    idle(4);
    feed_table(2);
    vsync_pulse();
    check_output("swap4_count", swap_cnt, 4);
    check_output("swap4_table_valid", int'(table_valid), 1);
    apply_stimulus(128, 0);
    apply_stimulus(255, 255);
    apply_stimulus(37, 0);
    idle(6);

    check_output("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
